frame_mask_engine: RTL and testbench
====================================

FRAME_MASK_ENGINE -- requirements
Module: frame_mask_engine

Interface
- REQ-001 SHALL have parameter W, default 8, frame width in pixels (>=3).
- REQ-002 SHALL have parameter H, default 8, frame height in pixels (>=3).
- REQ-003 SHALL have parameter PIXEL_WIDTH, default 8, bits per pixel.
- REQ-004 SHALL have parameter BORDER, default 1, width of the zeroed border ring (0 <= BORDER < min(W,H)/2).
- REQ-005 SHALL have parameter THRESH, default 128, binarisation threshold for mode 1.
- REQ-006 SHALL have derived ADDR_WIDTH = clog2(W*H).
- REQ-007 SHALL have one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock.
- REQ-008 rst_n  input  1  synchronous active-low reset.
- REQ-009 mode  input  2  processing mode, sampled on the first accepted pixel of each frame.
- REQ-010 in_valid  input  1  input pixel valid.
- REQ-011 in_ready  output  1  engine accepts an input pixel.
- REQ-012 in_data  input  PIXEL_WIDTH  input pixel, raster order.
- REQ-013 out_valid  output  1  output pixel valid.
- REQ-014 out_ready  input  1  downstream accepts an output pixel.
- REQ-015 out_data  output  PIXEL_WIDTH  processed pixel.
- REQ-016 out_addr  output  ADDR_WIDTH  raster index of out_data.
- REQ-017 out_last  output  1  high with the final pixel of a frame.
- REQ-018 frames_done  output  16  count of fully emitted frames, wraps at 65535->0.

Function
- REQ-019 SHALL implement two states: LOAD and EMIT.
- REQ-020 In LOAD, in_ready SHALL be 1. Each cycle with in_valid&in_ready SHALL store in_data at write index wr_idx, then increment wr_idx.
- REQ-021 Acceptance of pixel index W*H-1 SHALL clear wr_idx and enter EMIT on the next edge.
- REQ-022 In EMIT, in_ready SHALL be 0 and input SHALL be ignored.
- REQ-023 The first out_valid SHALL rise on the cycle after EMIT is entered, giving a one-cycle bubble, with out_addr=0.
- REQ-024 out_valid/out_data/out_addr/out_last SHALL be registered.
- REQ-025 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable.
- REQ-026 On each out_valid&out_ready, the next pixel SHALL be presented on the following cycle with no bubble.
- REQ-027 out_last SHALL be 1 only when out_addr=W*H-1.
- REQ-028 The handshake on out_last SHALL drop out_valid, increment frames_done, and return to LOAD; in_ready SHALL be 1 on the next cycle.
- REQ-029 Pixel (r,c) SHALL be a border pixel when r<BORDER, r>=H-BORDER, c<BORDER or c>=W-BORDER. Border pixels SHALL output 0 in every mode.
- REQ-030 Mode 0 (pass) SHALL output the stored pixel for interior pixels.
- REQ-031 Mode 1 (threshold) SHALL output all-ones when stored>=THRESH, else 0, for interior pixels.
- REQ-032 Mode 2 (erode) SHALL output the stored pixel for an interior pixel when it and all 8 neighbours are nonzero, else 0. Neighbours outside the frame SHALL count as zero.
- REQ-033 Mode 3 SHALL behave as mode 0.
- REQ-034 Mode SHALL be latched with pixel 0 of a frame and held through EMIT. Changes to the mode input mid-frame SHALL have no effect.
- REQ-035 Processing SHALL read only stored frame contents, never pixels already emitted.
- REQ-036 Row/column SHALL be tracked by separate counters, not by division.

Reset
- REQ-037 With rst_n=0 at a rising edge: state=LOAD, wr_idx=0, read index=0, out_valid=0, out_data=0, out_addr=0, out_last=0, frames_done=0, latched mode=0.
- REQ-038 in_ready SHALL be 0 while rst_n=0 and 1 on the first cycle after release.
- REQ-039 Reset mid-LOAD or mid-EMIT SHALL abandon the frame without incrementing frames_done. Frame memory contents are not cleared.

Verification
- REQ-040 W=H=8, BORDER=1, mode 0, in_data=index+1, out_ready=1 -> in_ready low after 64 accepts; one bubble; 64 outputs, addr 0..63; addr 9 -> 10, addr 0/7/56/63 -> 0; out_last at 63; frames_done=1.
- REQ-041 Mode 1, THRESH=128, interior pixels alternating 127/128 -> outputs alternate 0x00/0xFF; border 0.
- REQ-042 Mode 2, all pixels 5 except pixel 27=0 -> addr 27 and its 8 neighbours (18-20,26,28,34-36) output 0; other interior pixels output 5; borders 0.
- REQ-043 Mode 0, out_ready toggled on a pseudo-random pattern -> every out_* held stable while stalled; no pixel dropped or duplicated; sequence identical to the REQ-040 run.
- REQ-044 rst_n pulsed low after 30 accepts, then a full frame sent -> output matches the new frame only; frames_done=1.
- REQ-045 mode changed 1->0 mid-LOAD and mid-EMIT -> whole frame processed as mode 1; two back-to-back frames -> frames_done=2 and in_ready high the cycle after each out_last handshake.

Source files
------------

// File: rtl/frame_mask_engine.sv
// rtl/frame_mask_engine.sv - buffers one raster frame, then emits it with border masking and a per-frame pixel operator
module frame_mask_engine #(
    parameter int W           = 8,
    parameter int H           = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int BORDER      = 1,
    parameter int THRESH      = 128,
    parameter int ADDR_WIDTH  = $clog2(W * H)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic                   out_last,
    output logic [15:0]            frames_done
);

    localparam int N  = W * H;
    localparam int RW = $clog2(H + 1);
    localparam int CW = $clog2(W + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
    localparam logic [0:0] LOAD = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]             state;
    logic [PIXEL_WIDTH-1:0] mem [N];
    logic [ADDR_WIDTH-1:0]  wr_idx;
    logic [ADDR_WIDTH-1:0]  rd_idx;
    logic [RW-1:0]          rd_row;
    logic [CW-1:0]          rd_col;
    logic [1:0]             mode_q;
    logic                   accept;
    logic                   load_next;
    logic [PIXEL_WIDTH-1:0] center;
    logic [PIXEL_WIDTH-1:0] pix;
    logic                   all_nz;
    logic                   border;
    int                     r;
    int                     c;
    int                     nidx;

    assign in_ready  = rst_n && (state == LOAD);
    assign accept    = in_valid && in_ready;
    // The output register refills during the entry bubble and on every non-final handshake.
    assign load_next = (state == EMIT) && (!out_valid || (out_ready && !out_last));

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_idx] <= in_data;
        end
    end

    always_comb begin
        center = mem[rd_idx];
        all_nz = 1'b1;
        r      = 0;
        c      = 0;
        nidx   = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = int'(rd_row) + dr;
                c = int'(rd_col) + dc;
                if (r < 0 || r >= H || c < 0 || c >= W) begin
                    all_nz = 1'b0;
                end else begin
                    nidx = int'(rd_idx) + dr * W + dc;
                    if (mem[nidx[ADDR_WIDTH-1:0]] == '0) begin
                        all_nz = 1'b0;
                    end
                end
            end
        end
        border = (int'(rd_row) < BORDER) || (int'(rd_row) >= H - BORDER) ||
                 (int'(rd_col) < BORDER) || (int'(rd_col) >= W - BORDER);
        case (mode_q)
            2'd1:    pix = (int'(center) >= THRESH) ? '1 : '0;
            2'd2:    pix = all_nz ? center : '0;
            default: pix = center;
        endcase
        if (border) begin
            pix = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= LOAD;
            wr_idx      <= '0;
            rd_idx      <= '0;
            rd_row      <= '0;
            rd_col      <= '0;
            mode_q      <= 2'd0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_addr    <= '0;
            out_last    <= 1'b0;
            frames_done <= 16'd0;
        end else begin
            if (accept) begin
                if (wr_idx == '0) begin
                    mode_q <= mode;
                end
                if (wr_idx == LAST_IDX) begin
                    wr_idx <= '0;
                    rd_idx <= '0;
                    rd_row <= '0;
                    rd_col <= '0;
                    state  <= EMIT;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            if (load_next) begin
                out_valid <= 1'b1;
                out_data  <= pix;
                out_addr  <= rd_idx;
                out_last  <= (rd_idx == LAST_IDX);
                if (rd_idx == LAST_IDX) begin
                    rd_idx <= '0;
                    rd_row <= '0;
                    rd_col <= '0;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                    if (rd_col == CW'(W - 1)) begin
                        rd_col <= '0;
                        rd_row <= rd_row + 1'b1;
                    end else begin
                        rd_col <= rd_col + 1'b1;
                    end
                end
            end else if (state == EMIT && out_valid && out_ready && out_last) begin
                out_valid   <= 1'b0;
                state       <= LOAD;
                frames_done <= frames_done + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_mask_engine.sv
// tb/tb_frame_mask_engine.sv - directed and randomized frames checked against a per-pixel reference model
module tb_frame_mask_engine;

    localparam int W      = 8;
    localparam int H      = 8;
    localparam int N      = W * H;
    localparam int BORDER = 1;
    localparam int THRESH = 128;

    typedef logic [7:0] frame_t [N];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [5:0]  out_addr;
    logic        out_last;
    logic [15:0] frames_done;

    int     checks = 0;
    int     errors = 0;
    frame_t cur;
    frame_t got;

    always #5 clk = ~clk;

    frame_mask_engine #(
        .W(W), .H(H), .PIXEL_WIDTH(8), .BORDER(BORDER), .THRESH(THRESH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .frames_done(frames_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input frame_t f, input int m, input int i);
        int row;
        int col;
        row = i / W;
        col = i % W;
        if (row < BORDER || row >= H - BORDER || col < BORDER || col >= W - BORDER) return 8'h00;
        if (m == 1) return (f[i] >= THRESH) ? 8'hFF : 8'h00;
        if (m == 2) begin
            for (int rr = row - 1; rr <= row + 1; rr++)
                for (int cc = col - 1; cc <= col + 1; cc++)
                    if (rr < 0 || rr >= H || cc < 0 || cc >= W || f[rr * W + cc] == 8'h00) return 8'h00;
        end
        return f[i];
    endfunction

    task automatic send_frame(input int nsend, input logic [1:0] m_first, input logic [1:0] m_rest,
                              input bit gaps);
        int i;
        int cyc;
        i   = 0;
        cyc = 0;
        while (i < nsend && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            mode     = (i == 0) ? m_first : m_rest;
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = cur[i];
            if (in_valid && in_ready) i++;
        end
        check("send_count", i, nsend);
    endtask

    task automatic recv_frame(input int m_model, input logic [1:0] m_emit, input bit rnd_ready,
                              input int exp_fd);
        int k;
        int cyc;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        mode     = m_emit;
        check("bubble_out_valid", 32'(out_valid), 0);
        check("emit_in_ready", 32'(in_ready), 0);
        k   = 0;
        cyc = 0;
        while (k < N && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            in_data   = 8'($urandom);
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            check("out_valid_steady", 32'(out_valid), 1);
            if (out_valid) begin
                check("out_addr", 32'(out_addr), k);
                check("out_data", 32'(out_data), 32'(model(cur, m_model, k)));
                check("out_last", 32'(out_last), 32'(k == N - 1));
                if (out_ready) begin
                    if (out_last) in_valid = 1'b0;
                    got[k] = out_data;
                    k++;
                end
            end
        end
        check("recv_count", k, N);
        @(negedge clk);
        out_ready = 1'b1;
        check("post_in_ready", 32'(in_ready), 1);
        check("post_out_valid", 32'(out_valid), 0);
        check("frames_done", 32'(frames_done), exp_fd);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        mode      = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_addr", 32'(out_addr), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_frames_done", 32'(frames_done), 0);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 1);

        // pass-through ramp
        for (int i = 0; i < N; i++) cur[i] = 8'(i + 1);
        send_frame(N, 2'd0, 2'd0, 1'b0);
        recv_frame(0, 2'd0, 1'b0, 1);
        check("ramp_addr9", 32'(got[9]), 10);
        check("ramp_addr0", 32'(got[0]), 0);
        check("ramp_addr7", 32'(got[7]), 0);
        check("ramp_addr56", 32'(got[56]), 0);
        check("ramp_addr63", 32'(got[63]), 0);

        // threshold at the 127/128 boundary
        for (int i = 0; i < N; i++) cur[i] = (i % 2 == 1) ? 8'd128 : 8'd127;
        send_frame(N, 2'd1, 2'd1, 1'b0);
        recv_frame(1, 2'd1, 1'b0, 2);
        check("thr_addr9", 32'(got[9]), 32'hFF);
        check("thr_addr10", 32'(got[10]), 0);
        check("thr_addr15", 32'(got[15]), 0);

        // erode around a single zero
        for (int i = 0; i < N; i++) cur[i] = 8'd5;
        cur[27] = 8'd0;
        send_frame(N, 2'd2, 2'd2, 1'b0);
        recv_frame(2, 2'd2, 1'b0, 3);
        check("erode_addr27", 32'(got[27]), 0);
        check("erode_addr18", 32'(got[18]), 0);
        check("erode_addr36", 32'(got[36]), 0);
        check("erode_addr21", 32'(got[21]), 5);

        // ramp again under random backpressure and input gaps
        for (int i = 0; i < N; i++) cur[i] = 8'(i + 1);
        send_frame(N, 2'd0, 2'd0, 1'b1);
        recv_frame(0, 2'd0, 1'b1, 4);

        // mode latched as 1 then toggled mid-load and mid-emit, followed by a back-to-back erode frame
        for (int i = 0; i < N; i++) cur[i] = 8'($urandom);
        send_frame(N, 2'd1, 2'd0, 1'b1);
        recv_frame(1, 2'd0, 1'b1, 5);
        for (int i = 0; i < N; i++) cur[i] = 8'($urandom_range(0, 3));
        send_frame(N, 2'd2, 2'd1, 1'b0);
        recv_frame(2, 2'd0, 1'b1, 6);

        // reset abandons a partially loaded frame
        for (int i = 0; i < N; i++) cur[i] = 8'($urandom);
        send_frame(30, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 0);
        check("midrst_frames_done", 32'(frames_done), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        rst_n = 1'b1;
        #1;
        check("midrst_release_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < N; i++) cur[i] = 8'($urandom);
        send_frame(N, 2'd3, 2'd1, 1'b1);
        recv_frame(3, 2'd2, 1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
